// File: rtl/rr_merge_arbiter.sv
// Round-robin merge of four channel FIFOs into one output FIFO.
// Pops one non-empty channel per cycle; the popped word is pushed downstream two cycles later.
module rr_merge_arbiter #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    input  logic                  almost_full_out,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    output logic                  push_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    typedef enum logic [0:0] {StIdle, StPop} state_e;

    state_e                state_q, state_d;
    logic [3:0]            pop_q, pop_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            ptr_q, ptr_d;
    logic                  cap_v_q;
    logic [1:0]            cap_ch_q;
    logic                  push_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [3:0]            empty_vec;
    logic [3:0]            eligible;
    logic                  sel_found;
    logic [1:0]            sel_idx;
    logic [1:0]            idx;
    logic                  take;
    logic [DATA_WIDTH-1:0] cap_word;

    assign empty_vec = {empty_3, empty_2, empty_1, empty_0};
    // A channel popped this cycle still shows its pre-pop empty flag, so mask it.
    assign eligible  = ~empty_vec & ~pop_q;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        idx       = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    assign take = sel_found && !almost_full_out;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = StIdle;
        if (take) begin
            state_d = StPop;
        end
    end

    // FSM output logic
    always_comb begin
        busy = (state_q == StPop);
    end

    always_comb begin
        pop_d   = '0;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (take) begin
            pop_d   = 4'b0001 << sel_idx;
            grant_d = sel_idx;
            ptr_d   = sel_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            pop_q   <= pop_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        cap_word = data_in_0;
        case (cap_ch_q)
            2'd0:    cap_word = data_in_0;
            2'd1:    cap_word = data_in_1;
            2'd2:    cap_word = data_in_2;
            default: cap_word = data_in_3;
        endcase
    end

    // Channel read data is valid the cycle after the pop, so capture one cycle late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_v_q  <= 1'b0;
            cap_ch_q <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            cap_v_q  <= |pop_q;
            cap_ch_q <= grant_q;
            push_q   <= cap_v_q;
            if (cap_v_q) begin
                data_q <= cap_word;
            end
            if (push_q) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign pop_0      = pop_q[0];
    assign pop_1      = pop_q[1];
    assign pop_2      = pop_q[2];
    assign pop_3      = pop_q[3];
    assign push_out   = push_q;
    assign data_out   = data_q;
    assign grant      = grant_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Bench for rr_merge_arbiter: behavioural channel FIFOs plus a cycle-level model of
// round-robin selection, a push scoreboard and a modulo-256 push counter.
module tb_rr_merge_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  empty;
    logic [11:0] din [4];
    logic        af;
    wire  [3:0]  pop;
    wire         push_out;
    wire  [11:0] data_out;
    wire  [1:0]  grant;
    wire         busy;
    wire  [7:0]  word_count;

    rr_merge_arbiter #(
        .DATA_WIDTH (12),
        .CNT_WIDTH  (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .empty_0         (empty[0]),
        .empty_1         (empty[1]),
        .empty_2         (empty[2]),
        .empty_3         (empty[3]),
        .data_in_0       (din[0]),
        .data_in_1       (din[1]),
        .data_in_2       (din[2]),
        .data_in_3       (din[3]),
        .almost_full_out (af),
        .pop_0           (pop[0]),
        .pop_1           (pop[1]),
        .pop_2           (pop[2]),
        .pop_3           (pop[3]),
        .push_out        (push_out),
        .data_out        (data_out),
        .grant           (grant),
        .busy            (busy),
        .word_count      (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel FIFO contents
    logic [11:0] q0[$], q1[$], q2[$], q3[$];
    logic [11:0] exp_q[$];

    function automatic int fsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [11:0] ffront(int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            2:       return q2[0];
            default: return q3[0];
        endcase
    endfunction

    function automatic logic [11:0] fpop(int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            2:       return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    function automatic void fpush(int k, logic [11:0] w);
        case (k)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            2:       q2.push_back(w);
            default: q3.push_back(w);
        endcase
    endfunction

    function automatic void update_empty();
        for (int k = 0; k < 4; k++) empty[k] = (fsize(k) == 0);
    endfunction

    // Reference model state
    int         m_ptr;
    int         m_cur;
    int         m_count;
    bit         d1, d2;
    logic [3:0] rec_pop;
    int         af_rate;
    int         refill_rate;

    function automatic void model_reset();
        m_ptr   = 0;
        m_cur   = -1;
        m_count = 0;
        d1      = 0;
        d2      = 0;
        rec_pop = '0;
        exp_q.delete();
    endfunction

    task automatic step();
        int          pred;
        int          k;
        logic [11:0] pred_word;
        bit          exp_push;
        pred      = -1;
        pred_word = '0;
        if (!af) begin
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (pred < 0 && !empty[k] && k != m_cur) pred = k;
            end
        end
        if (pred >= 0) pred_word = ffront(pred);

        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) check($sformatf("pop_%0d", c), 32'(pop[c]), 32'(pred == c));
        check("busy", 32'(busy), 32'(pred >= 0));
        if (pred >= 0) check("grant", 32'(grant), 32'(pred));

        exp_push = d2;
        d2 = d1;
        d1 = (pred >= 0);
        check("push_out", 32'(push_out), 32'(exp_push));
        if (exp_push && exp_q.size() > 0) check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        check("word_count", 32'(word_count), 32'(m_count));
        if (exp_push) m_count = (m_count + 1) % 256;
        if (pred >= 0) begin
            exp_q.push_back(pred_word);
            m_ptr = (pred + 1) % 4;
        end
        m_cur = pred;

        // Channel FIFOs see last cycle's pop at this edge and present the word now.
        for (int c = 0; c < 4; c++) begin
            if (rec_pop[c] && fsize(c) > 0) din[c] = fpop(c);
        end
        rec_pop = pop;

        if (refill_rate > 0 && $urandom_range(99) < refill_rate) begin
            fpush($urandom_range(3), 12'($urandom));
        end
        af = ($urandom_range(99) < af_rate);
        update_empty();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        af_rate     = 0;
        refill_rate = 0;
        af          = 1'b0;
        while ((fsize(0) + fsize(1) + fsize(2) + fsize(3) > 0 || d1 || d2 || m_cur >= 0
                || rec_pop != 0) && n < 3000) begin
            step();
            n++;
        end
        repeat (2) step();
        if (n >= 3000) check({tag, "_drain_timeout"}, 32'(n), 32'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_pop", 32'(pop), 32'(0));
        check("rst_push_out", 32'(push_out), 32'(0));
        check("rst_data_out", 32'(data_out), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_word_count", 32'(word_count), 32'(0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        empty       = 4'hF;
        af          = 1'b0;
        af_rate     = 0;
        refill_rate = 0;
        for (int c = 0; c < 4; c++) din[c] = '0;
        model_reset();
        #2;
        do_reset();

        // All four channels loaded; expect pops 0,1,2,3 back to back.
        fpush(0, 12'h00A);
        fpush(1, 12'h10B);
        fpush(2, 12'h20C);
        fpush(3, 12'h30D);
        update_empty();
        drain("all_full");
        check("all_full_count", 32'(word_count), 32'(4));

        // Single active channel: pops must alternate with idle cycles.
        fpush(2, 12'h2A1);
        fpush(2, 12'h2A2);
        fpush(2, 12'h2A3);
        update_empty();
        drain("single");
        check("single_count", 32'(word_count), 32'(7));

        // Move ptr to 1, then only channel 3 holds data: it must be skipped to.
        fpush(0, 12'h0C1);
        update_empty();
        drain("ptr_to_1");
        fpush(3, 12'h3C1);
        update_empty();
        drain("skip");
        fpush(0, 12'h0C2);
        fpush(1, 12'h1C2);
        update_empty();
        drain("after_skip");

        // Back-pressure raised right after a pop is issued.
        for (int c = 0; c < 4; c++) begin
            fpush(c, 12'h400 + 12'(c));
            fpush(c, 12'h410 + 12'(c));
        end
        update_empty();
        step();
        af_rate = 100;
        af      = 1'b1;
        repeat (5) step();
        af_rate = 0;
        af      = 1'b0;
        drain("backpressure");

        // Randomized traffic with intermittent back-pressure.
        af_rate     = 25;
        refill_rate = 60;
        repeat (600) step();
        drain("random");

        // Reset with a pop in flight.
        for (int c = 0; c < 4; c++) fpush(c, 12'h500 + 12'(c));
        update_empty();
        step();
        step();
        #2;
        do_reset();
        drain("post_reset");

        // Wrap the counter: exactly 256 words after a fresh reset.
        do_reset();
        for (int n = 0; n < 256; n++) fpush(n % 4, 12'($urandom));
        update_empty();
        drain("wrap");
        check("wrap_count", 32'(word_count), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
